// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_pkg : shared types and constants for the ALU command issuer          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package alu_pkg;

    localparam int ALU_W = 8;
    localparam int LAT_W = 8;

    localparam logic [3:0] CMD_MUL_INC   = 4'd9;
    localparam logic [3:0] CMD_MUL_SHIFT = 4'd10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } issuer_state_e;

    typedef struct packed {
        logic             mode;
        logic [3:0]       cmd;
        logic             cin;
        logic [1:0]       inp_valid;
        logic [ALU_W-1:0] opa;
        logic [ALU_W-1:0] opb;
    } alu_req_t;

    function automatic logic is_mul_cmd(input logic mode, input logic [3:0] cmd);
        return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHIFT));
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_lat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_lat_counter : loadable down-counter, o_done high while count == 1    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module alu_lat_counter
    import alu_pkg::*;
#(
    parameter int CNT_W = LAT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_done = (cnt_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_cmd_issuer : one-at-a-time ALU command initiator with response port  |
// | Optional statistics counters: define ALU_CMD_ISSUER_STATS_EN. Rev 1.0    |
// +--------------------------------------------------------------------------+
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1,
    parameter int MUL_LAT = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_mode,
    input  logic [3:0]         req_cmd,
    input  logic               req_cin,
    input  logic [1:0]         req_inp_valid,
    input  logic [WIDTH-1:0]   req_opa,
    input  logic [WIDTH-1:0]   req_opb,
    output logic [WIDTH-1:0]   OPA,
    output logic [WIDTH-1:0]   OPB,
    output logic               CIN,
    output logic               CE,
    output logic               MODE,
    output logic [3:0]         CMD,
    output logic [1:0]         INP_VALID,
    input  logic [2*WIDTH-1:0] RES,
    input  logic               COUT,
    input  logic               OFLOW,
    input  logic               ERR,
    input  logic               G,
    input  logic               L,
    input  logic               E,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_res,
    output logic [6:0]         rsp_flags,
    output logic [15:0]        op_count,
    output logic [15:0]        err_count
);

    issuer_state_e      state_q, state_d;
    logic               mode_q, mode_d;
    logic [3:0]         cmd_q, cmd_d;
    logic               cin_q, cin_d;
    logic [1:0]         iv_q, iv_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic [6:0]         flags_q, flags_d;
    logic               cnt_load;
    logic               cnt_done;
    logic               rsp_hs;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cmd_d    = cmd_q;
        cin_d    = cin_q;
        iv_d     = iv_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        lat_d    = lat_q;
        res_d    = res_q;
        flags_d  = flags_q;
        cnt_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mode_d  = req_mode;
                    cmd_d   = req_cmd;
                    cin_d   = req_cin;
                    iv_d    = req_inp_valid;
                    opa_d   = req_opa;
                    opb_d   = req_opb;
                    lat_d   = is_mul_cmd(req_mode, req_cmd) ? LAT_W'(MUL_LAT) : LAT_W'(ALU_LAT);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_load = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                // The ALU result is sampled on the edge that closes the last latency cycle.
                if (cnt_done) begin
                    res_d   = RES;
                    flags_d = {COUT, OFLOW, ERR, G, L, E, 1'b0};
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            cmd_q   <= 4'd0;
            cin_q   <= 1'b0;
            iv_q    <= 2'b00;
            opa_q   <= '0;
            opb_q   <= '0;
            lat_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cmd_q   <= cmd_d;
            cin_q   <= cin_d;
            iv_q    <= iv_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            lat_q   <= lat_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    alu_lat_counter #(
        .CNT_W (LAT_W)
    ) u_lat_counter (
        .clk        (CLK),
        .rst_n      (RST),
        .i_load     (cnt_load),
        .i_load_val (lat_q),
        .o_done     (cnt_done)
    );

    // Gating with RST keeps req_ready low for the whole reset window.
    assign req_ready = RST && (state_q == IDLE);
    assign CE        = (state_q == ISSUE);
    assign INP_VALID = CE ? iv_q : 2'b00;
    assign OPA       = opa_q;
    assign OPB       = opb_q;
    assign CIN       = cin_q;
    assign MODE      = mode_q;
    assign CMD       = cmd_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_res   = res_q;
    assign rsp_flags = flags_q;
    assign rsp_hs    = rsp_valid && rsp_ready;

`ifdef ALU_CMD_ISSUER_STATS_EN
    logic [15:0] op_count_q, op_count_d;
    logic [15:0] err_count_q, err_count_d;

    always_comb begin
        op_count_d  = op_count_q;
        err_count_d = err_count_q;
        if (rsp_hs) begin
            if (op_count_q != 16'hFFFF) begin
                op_count_d = op_count_q + 16'd1;
            end
            if (flags_q[4] && (err_count_q != 16'hFFFF)) begin
                err_count_d = err_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            op_count_q  <= 16'd0;
            err_count_q <= 16'd0;
        end else begin
            op_count_q  <= op_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign op_count  = op_count_q;
    assign err_count = err_count_q;
`else
    assign op_count  = 16'd0;
    assign err_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_cmd_issuer : self-checking bench with a stub ALU of programmable  |
// | latency and a response reference model. Rev 1.0                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_alu_cmd_issuer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_mode = 1'b0;
    logic [3:0]  req_cmd = 4'd0;
    logic        req_cin = 1'b0;
    logic [1:0]  req_inp_valid = 2'b00;
    logic [7:0]  req_opa = 8'd0;
    logic [7:0]  req_opb = 8'd0;
    logic [7:0]  OPA, OPB;
    logic        CIN, CE, MODE;
    logic [3:0]  CMD;
    logic [1:0]  INP_VALID;
    logic [15:0] RES = 16'h0;
    logic        COUT = 1'b0, OFLOW = 1'b0, ERR = 1'b0, G = 1'b0, L = 1'b0, E = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_res;
    logic [6:0]  rsp_flags;
    logic [15:0] op_count, err_count;

    int total = 0;
    int bad   = 0;
    int exp_ops  = 0;
    int exp_errs = 0;

    always #5 CLK = ~CLK;

    alu_cmd_issuer #(
        .WIDTH   (8),
        .ALU_LAT (1),
        .MUL_LAT (2)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_mode      (req_mode),
        .req_cmd       (req_cmd),
        .req_cin       (req_cin),
        .req_inp_valid (req_inp_valid),
        .req_opa       (req_opa),
        .req_opb       (req_opb),
        .OPA           (OPA),
        .OPB           (OPB),
        .CIN           (CIN),
        .CE            (CE),
        .MODE          (MODE),
        .CMD           (CMD),
        .INP_VALID     (INP_VALID),
        .RES           (RES),
        .COUT          (COUT),
        .OFLOW         (OFLOW),
        .ERR           (ERR),
        .G             (G),
        .L             (L),
        .E             (E),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_res       (rsp_res),
        .rsp_flags     (rsp_flags),
        .op_count      (op_count),
        .err_count     (err_count)
    );

    // Reference response: {RES[15:0], COUT, OFLOW, ERR, G, L, E, 0}
    function automatic logic [22:0] ref_rsp(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] iv);
        int unsigned sum;
        logic [7:0]  s8;
        logic        ovf;
        sum = int'(a) + int'(b);
        s8  = sum[7:0];
        ovf = (a[7] == b[7]) && (s8[7] != a[7]);
        return {8'h00, s8, (sum > 255), ovf, (iv == 2'b00), (a > b), (a < b), (a == b), 1'b0};
    endfunction

    function automatic int lat_of(input logic m, input logic [3:0] c);
        return (m && (c == 4'd9 || c == 4'd10)) ? 2 : 1;
    endfunction

    // Stub ALU: correct outputs only during the lat-th cycle after the CE cycle, junk otherwise.
    int          s_age = 100;
    int          s_lat = 1;
    logic [22:0] s_good = 23'h0;
    always @(negedge CLK) begin
        if (CE === 1'b1) begin
            s_good = ref_rsp(OPA, OPB, INP_VALID);
            s_lat  = lat_of(MODE, CMD);
            s_age  = 0;
        end else if (s_age < 100) begin
            s_age = s_age + 1;
        end
        if (s_age == s_lat) {RES, COUT, OFLOW, ERR, G, L, E} = s_good[22:1];
        else                {RES, COUT, OFLOW, ERR, G, L, E} = ~s_good[22:1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats();
`ifdef ALU_CMD_ISSUER_STATS_EN
        chk("op_count", op_count, exp_ops);
        chk("err_count", err_count, exp_errs);
`else
        chk("op_count_tied", op_count, 0);
        chk("err_count_tied", err_count, 0);
`endif
    endtask

    // Called at a negedge with the DUT idle.
    task automatic run_op(input logic m, input logic [3:0] c, input logic ci,
                          input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b,
                          input int hold);
        logic [22:0] e;
        int          lat;
        int          k;
        e   = ref_rsp(a, b, iv);
        lat = lat_of(m, c);
        chk("idle_ready", req_ready, 1);
        req_valid = 1'b1; req_mode = m; req_cmd = c; req_cin = ci;
        req_inp_valid = iv; req_opa = a; req_opb = b;
        @(posedge CLK); @(negedge CLK);
        chk("issue_ce", CE, 1);
        chk("issue_opa", OPA, a);
        chk("issue_opb", OPB, b);
        chk("issue_iv", INP_VALID, iv);
        chk("issue_cmd", CMD, c);
        chk("issue_mode", MODE, m);
        chk("issue_cin", CIN, ci);
        chk("issue_ready", req_ready, 0);
        // Keep a junk request pending: a busy issuer must ignore it.
        req_opa = ~a; req_opb = ~b; req_cmd = ~c; req_inp_valid = ~iv;
        k = 0;
        while (rsp_valid !== 1'b1 && k <= lat + 4) begin
            @(posedge CLK); k++; @(negedge CLK);
            if (rsp_valid !== 1'b1) begin
                chk("wait_ce", CE, 0);
                chk("wait_iv", INP_VALID, 0);
                chk("wait_opa_hold", OPA, a);
                chk("wait_cmd_hold", CMD, c);
            end
        end
        chk("latency", k, lat + 1);
        req_valid = 1'b0;
        chk("rsp_res", rsp_res, e[22:7]);
        chk("rsp_flags", rsp_flags, e[6:0]);
        chk("rsp_ready_low", req_ready, 0);
        if (hold > 0) begin
            rsp_ready = 1'b0;
            repeat (hold) begin
                @(posedge CLK); @(negedge CLK);
                chk("bp_valid", rsp_valid, 1);
                chk("bp_res", rsp_res, e[22:7]);
                chk("bp_flags", rsp_flags, e[6:0]);
                chk("bp_ready", req_ready, 0);
            end
            rsp_ready = 1'b1;
        end
        @(posedge CLK); @(negedge CLK);
        if (exp_ops < 65535) exp_ops++;
        if (iv == 2'b00 && exp_errs < 65535) exp_errs++;
        chk("post_valid", rsp_valid, 0);
        chk("post_ready", req_ready, 1);
        chk_stats();
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_ce", CE, 0);
        chk("rst_iv", INP_VALID, 0);
        chk("rst_opa", OPA, 0);
        chk("rst_opb", OPB, 0);
        chk("rst_cmd", CMD, 0);
        chk("rst_res", rsp_res, 0);
        chk("rst_flags", rsp_flags, 0);
        chk("rst_opcnt", op_count, 0);
        RST = 1'b1;
        #1;
        chk("first_idle_ready", req_ready, 1);
        @(negedge CLK);

        // Directed: add, multiply latency, backpressure, invalid operands
        run_op(1'b1, 4'd0,  1'b0, 2'd3, 8'h0F, 8'h01, 0);
        run_op(1'b1, 4'd9,  1'b1, 2'd3, 8'h12, 8'h34, 0);
        run_op(1'b1, 4'd10, 1'b0, 2'd1, 8'hF0, 8'h20, 0);
        run_op(1'b0, 4'd9,  1'b0, 2'd3, 8'h80, 8'h80, 0);
        run_op(1'b1, 4'd1,  1'b0, 2'd2, 8'hA5, 8'h5A, 5);
        run_op(1'b1, 4'd0,  1'b0, 2'd0, 8'h33, 8'h33, 0);

        // Mid-operation reset during WAIT
        req_valid = 1'b1; req_mode = 1'b1; req_cmd = 4'd9; req_cin = 1'b1;
        req_inp_valid = 2'd3; req_opa = 8'h77; req_opb = 8'h11;
        @(posedge CLK); @(negedge CLK);
        req_valid = 1'b0;
        @(posedge CLK); @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("mrst_ce", CE, 0);
        chk("mrst_valid", rsp_valid, 0);
        chk("mrst_ready", req_ready, 0);
        chk("mrst_opa", OPA, 0);
        chk("mrst_cin", CIN, 0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("mrst_idle_ready", req_ready, 1);
        exp_ops  = 0;
        exp_errs = 0;
        repeat (4) begin
            @(negedge CLK);
            chk("mrst_no_rsp", rsp_valid, 0);
        end
        chk_stats();

        // Randomized operations
        for (int i = 0; i < 20; i++) begin
            logic [3:0] c;
            case ($urandom_range(0, 3))
                0:       c = 4'd9;
                1:       c = 4'd10;
                default: c = 4'($urandom_range(0, 15));
            endcase
            run_op(1'($urandom_range(0, 1)), c, 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 3)));
        end

`ifdef ALU_CMD_ISSUER_STATS_EN
        // Saturation of the op counter
        force dut.op_count_q = 16'hFFFE;
        #1;
        release dut.op_count_q;
        exp_ops = 65534;
        repeat (3) run_op(1'b1, 4'd0, 1'b0, 2'd3, 8'h01, 8'h02, 0);
        chk("op_count_sat", op_count, 16'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Synthesizable initiator for the ALU operand/command interface. Accepts one operation request over a valid/ready handshake, drives OPA/OPB/CIN/CE/MODE/CMD/INP_VALID into the ALU for one cycle, and waits the command-dependent ALU latency. It then captures RES/COUT/OFLOW/ERR/G/L/E and returns them on a valid/ready response channel. It sits between an on-chip command source and the ALU, and is the hardware counterpart of the bench driver/monitor pair.

## Interface
- WIDTH, 8: operand width; RES is 2*WIDTH.
- ALU_LAT, 1: ALU result latency in cycles for non-multiply commands, ≥1.
- MUL_LAT, 2: latency for multiply commands (MODE=1, CMD=9 or 10), ≥1.
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  issuer can accept; high only in IDLE.
- req_mode, req_cmd, req_cin, req_inp_valid  in  1/4/1/2  operation fields.
- req_opa, req_opb  in  WIDTH  operands.
- OPA, OPB  out  WIDTH  to ALU.
- CIN, CE, MODE  out  1  to ALU.
- CMD  out  4  to ALU.
- INP_VALID  out  2  to ALU.
- RES  in  2*WIDTH  from ALU.
- COUT, OFLOW, ERR, G, L, E  in  1  from ALU.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts.
- rsp_res  out  2*WIDTH  captured result.
- rsp_flags  out  7  {COUT,OFLOW,ERR,G,L,E,timeout_unused=0}; bit 0 always 0.
- op_count, err_count  out  16  statistics (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset → IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready, register all req fields, select L = MUL_LAT if mode=1 and cmd∈{9,10}, else ALU_LAT; go ISSUE.
- ISSUE (exactly 1 cycle): CE=1, INP_VALID=registered req_inp_valid, OPA/OPB/CIN/MODE/CMD = registered values; load wait counter with L; go WAIT.
- WAIT: CE=0, INP_VALID=0; OPA/OPB/CIN/MODE/CMD hold last issued values. Counter decrements each cycle; when counter==1, capture RES and flags at that cycle's closing edge; go RESP.
- RESP: rsp_valid=1, rsp_res/rsp_flags stable until rsp_valid&&rsp_ready; then → IDLE. No new request is accepted in the same cycle.
- req_inp_valid=2'b00 is still issued; the ALU's ERR response is captured unchanged. The issuer does no error checking of its own.
- One operation outstanding at a time; no pipelining.

## Timing
- Handshake accepted at edge t → ISSUE during cycle t+1 → WAIT cycles t+2 … t+1+L → rsp_valid high from cycle t+2+L.
- Minimum request-to-response latency is L+2 cycles. Next req_ready is one cycle after the rsp handshake.
- Reset values: req_ready=0 while RST low and 1 in the first IDLE cycle after release. rsp_valid=0, CE=0, INP_VALID=0, OPA=OPB=0, CIN=MODE=0, CMD=0, rsp_res=0, rsp_flags=0, counters=0.
- Reset asserted in any state aborts the operation immediately: outputs go to reset values, any pending response is lost.
- rsp_ready held high while rsp_valid=0 has no effect. rsp_ready low leaves RESP held indefinitely with outputs stable.

## Configuration
- ALU_CMD_ISSUER_STATS_EN defined:
  - op_count increments on every rsp handshake.
  - err_count increments on every rsp handshake with captured ERR=1.
  - Both saturate at 16'hFFFF and reset to 0.
- Not defined: op_count and err_count are tied to 0 and no counter flops exist.

## Structure
- Shared package alu_pkg gains:
  - issuer_state_e enum {IDLE, ISSUE, WAIT, RESP}
  - constants CMD_MUL_INC=4'd9 and CMD_MUL_SHIFT=4'd10
  - packed struct alu_req_t {mode, cmd, cin, inp_valid, opa, opb}
- One sub-module: alu_lat_counter, a loadable down-counter with a done pulse, reused for both latency values.

## Test plan
Bench uses a stub ALU that returns RES = {8'h00, OPA+OPB}, ERR = (INP_VALID==0), and has a programmable latency.
- Single add: mode=1, cmd=0, opa=8'h0F, opb=8'h01, inp_valid=3, ALU_LAT=1 → one-cycle CE pulse with OPA=0F, OPB=01. rsp_valid 3 cycles after accept, rsp_res=16'h0010.
- Multiply latency: mode=1, cmd=9, MUL_LAT=2 → rsp_valid 4 cycles after accept; capture happens at the second WAIT edge.
- Backpressure: rsp_ready low for 5 cycles → rsp_res and rsp_flags stable and req_ready=0 throughout. Raise rsp_ready → req_ready=1 the next cycle.
- Invalid operands: inp_valid=0 → response has ERR=1. With ALU_CMD_ISSUER_STATS_EN, err_count goes 0→1 and op_count goes 0→1.
- Mid-operation reset: drive RST low during WAIT → CE=0 and rsp_valid=0 immediately. After release, IDLE with req_ready=1 and no response emitted.
- Saturation (STATS_EN): force op_count to 16'hFFFE, complete 3 ops → op_count reads 16'hFFFF.
